// File: rtl/acc_pkg.sv
// Shared types and the per-pixel operation for the streaming pixel-map accelerator.
package acc_pkg;

    typedef enum logic [1:0] {
        MODE_COPY   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_BRIGHT = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_FILL  = 3'd2,
        S_RD    = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] PIX_MAX = 8'd255;
    localparam logic [7:0] PIX_MIN = 8'd0;

    function automatic logic [7:0] pixel_op(input mode_e m, input logic [7:0] p,
                                            input logic [7:0] t);
        logic [8:0] sum;
        logic [7:0] res;
        sum = {1'b0, p} + {1'b0, t};
        case (m)
            MODE_COPY:   res = p;
            MODE_INVERT: res = PIX_MAX - p;
            MODE_THRESH: res = (p >= t) ? PIX_MAX : PIX_MIN;
            MODE_BRIGHT: res = sum[8] ? PIX_MAX : sum[7:0];
            default:     res = p;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/acc_pixel_lane.sv
// Combinational 4-lane pixel operation applied to one packed 32-bit word.
module acc_pixel_lane
    import acc_pkg::*;
(
    input  mode_e       mode_i,
    input  logic [7:0]  thr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign data_o[g*8 +: 8] = pixel_op(mode_i, data_i[g*8 +: 8], thr_i);
    end

endmodule

// File: rtl/acc_pixel_map.sv
// Streams an image from SRC_BASE to DST_BASE through a per-pixel op, alternating
// read and write on the single-port memory (one word per two cycles).
module acc_pixel_map
    import acc_pkg::*;
#(
    parameter int IMG_W    = 352,
    parameter int IMG_H    = 288,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = IMG_W * IMG_H / 4,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    input  logic [31:0]       dataR,
    output logic [31:0]       dataW,
    output logic              en,
    output logic              we,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [7:0]        thr,
    output logic              finish,
    output state_t            dbg_state
);

    localparam int N_WORDS = IMG_W * IMG_H / 4;
    localparam int CNT_W   = $clog2(N_WORDS + 1);

    localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0]  NW    = CNT_W'(N_WORDS);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rd_k_q, rd_k_d;
    logic [CNT_W-1:0] wr_k_q, wr_k_d;
    logic [31:0]      out_q, out_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       thr_q, thr_d;
    logic [31:0]      lane_out;

    acc_pixel_lane u_lane (
        .mode_i (mode_q),
        .thr_i  (thr_q),
        .data_i (dataR),
        .data_o (lane_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rd_k_q  <= '0;
            wr_k_q  <= '0;
            out_q   <= '0;
            mode_q  <= MODE_COPY;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_k_q  <= rd_k_d;
            wr_k_q  <= wr_k_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
        end
    end

    // Memory protocol: a request is en=1 for one cycle; with we=0 the word at addr
    // appears on dataR in the following cycle, with we=1 dataW is stored at addr.
    always_comb begin
        state_d = state_q;
        rd_k_d  = rd_k_q;
        wr_k_d  = wr_k_q;
        out_d   = out_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        en      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode_e'(mode);
                    thr_d   = thr;
                    rd_k_d  = '0;
                    wr_k_d  = '0;
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                en      = 1'b1;
                addr    = SRC_A;
                rd_k_d  = ONE;
                state_d = S_FILL;
            end
            S_FILL: begin
                en      = 1'b1;
                addr    = SRC_A + ADDR_W'(1);
                out_d   = lane_out;
                rd_k_d  = CNT_W'(2);
                state_d = S_WR;
            end
            S_WR: begin
                en     = 1'b1;
                we     = 1'b1;
                addr   = DST_A + ADDR_W'(wr_k_q);
                out_d  = lane_out;
                wr_k_d = wr_k_q + ONE;
                if (wr_k_q == LAST) begin
                    state_d = S_DONE;
                end else if (rd_k_q < NW) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_WR;
                end
            end
            S_RD: begin
                en      = 1'b1;
                addr    = SRC_A + ADDR_W'(rd_k_q);
                rd_k_d  = rd_k_q + ONE;
                state_d = S_WR;
            end
            S_DONE: begin
                finish = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dataW     = out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_pixel_map.sv
// Directed bench for acc_pixel_map on a 4-word image with a behavioural memory.
module tb_acc_pixel_map;
  import acc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  thr;
  logic        finish;
  state_t      dbg_state;

  logic [31:0] mem [0:65535];
  logic [31:0] src [0:3];
  int          n_checks = 0;
  int          n_fails = 0;
  logic [31:0] sentinel = 32'hDEAD_BEEF;

  acc_pixel_map #(
    .IMG_W(8), .IMG_H(2), .SRC_BASE(0), .DST_BASE(4), .ADDR_W(16)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .dataW(dataW),
    .en(en), .we(we), .start(start), .mode(mode), .thr(thr),
    .finish(finish), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en && we) mem[addr] = dataW;
    if (en && !we) dataR <= mem[addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int m, input logic [7:0] t, input logic [31:0] w);
    logic [31:0] r;
    int p;
    for (int b = 0; b < 4; b++) begin
      p = int'(w[b*8 +: 8]);
      case (m)
        0: p = p;
        1: p = 255 - p;
        2: p = (p >= int'(t)) ? 255 : 0;
        default: p = (p + int'(t) > 255) ? 255 : p + int'(t);
      endcase
      r[b*8 +: 8] = p[7:0];
    end
    return r;
  endfunction

  task automatic clear_dst();
    for (int i = 4; i < 12; i++) mem[i] = sentinel;
  endtask

  task automatic wait_finish(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (finish !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic check_dst(input string tag, input int m, input logic [7:0] t);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_w%0d", tag, i + 4), mem[i + 4], model(m, t, src[i]));
    check({tag, "_w8_untouched"}, mem[8], sentinel);
  endtask

  task automatic run_op(input string tag, input int m, input logic [7:0] t);
    clear_dst();
    mode = 2'(m);
    thr = t;
    start = 1'b1;
    tick();
    check({tag, "_prime"}, 32'(dbg_state), 32'(S_PRIME));
    wait_finish(tag, 8);
    start = 1'b0;
    tick();
    check({tag, "_idle"}, 32'(dbg_state), 32'(S_IDLE));
    check_dst(tag, m, t);
  endtask

  logic        exp_we [0:7];
  logic [15:0] exp_ad [0:7];

  initial begin
    src[0] = 32'h0040_80FF;
    src[1] = 32'h0102_0304;
    src[2] = 32'h7F80_FE10;
    src[3] = 32'hAA55_00FF;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = src[i];
    exp_we = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_ad = '{16'd0, 16'd1, 16'd4, 16'd2, 16'd5, 16'd3, 16'd6, 16'd7};
    dataR = 32'h0;
    reset = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    thr = 8'd0;

    // Reset state
    repeat (3) tick();
    check("rst_en", 32'(en), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_dataW", dataW, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    tick();
    check("idle_en", 32'(en), 32'd0);

    // COPY with bus sequence and latency, start held throughout
    clear_dst();
    mode = 2'd0;
    start = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      check($sformatf("copy_en_c%0d", c), 32'(en), 32'd1);
      check($sformatf("copy_we_c%0d", c), 32'(we), 32'(exp_we[c]));
      check($sformatf("copy_addr_c%0d", c), 32'(addr), 32'(exp_ad[c]));
      check($sformatf("copy_fin_c%0d", c), 32'(finish), 32'd0);
      tick();
    end
    check("copy_finish_at_8", 32'(finish), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("done_hold_fin_%0d", c), 32'(finish), 32'd1);
      check($sformatf("done_hold_en_%0d", c), 32'(en), 32'd0);
      tick();
    end
    start = 1'b0;
    tick();
    check("drop_start_idle", 32'(dbg_state), 32'(S_IDLE));
    check("drop_start_fin", 32'(finish), 32'd0);
    check_dst("copy", 0, 8'd0);

    // INVERT, THRESH, BRIGHT with hand-computed words
    run_op("invert", 1, 8'd0);
    check("invert_w4_hand", mem[4], 32'hFFBF_7F00);
    check("invert_w7_hand", mem[7], 32'h55AA_FF00);
    run_op("thresh", 2, 8'h80);
    check("thresh_w4_hand", mem[4], 32'h0000_FFFF);
    check("thresh_w6_hand", mem[6], 32'h00FF_FF00);
    run_op("bright", 3, 8'h80);
    check("bright_w4_hand", mem[4], 32'h80C0_FFFF);
    check("bright_w5_hand", mem[5], 32'h8182_8384);

    // Mode/thr changes mid-run are ignored
    clear_dst();
    mode = 2'd0;
    thr = 8'd0;
    start = 1'b1;
    tick();
    tick();
    tick();
    mode = 2'd1;
    thr = 8'h33;
    wait_finish("modechg", 6);
    start = 1'b0;
    tick();
    check_dst("modechg", 0, 8'd0);

    // Reset during the third write abandons the rest of the image
    clear_dst();
    mode = 2'd0;
    thr = 8'd0;
    start = 1'b1;
    tick();
    repeat (6) tick();
    check("third_wr_state", 32'(dbg_state), 32'(S_WR));
    check("third_wr_addr", 32'(addr), 32'd6);
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("midrst_en", 32'(en), 32'd0);
    check("midrst_fin", 32'(finish), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    tick();
    tick();
    check("midrst_en_after", 32'(en), 32'd0);
    check("midrst_w6", mem[6], src[2]);
    check("midrst_w7_untouched", mem[7], sentinel);
    run_op("after_rst", 0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
